// File: rtl/spfp_mul_seq.sv
// rtl/spfp_mul_seq.sv - iterative IEEE-754 single-precision multiplier
// One shift-add step per cycle over 24 cycles, then round-to-nearest-even.
module spfp_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] n1,
  input  logic [31:0] n2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        ovf,
  output logic        unf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MULT  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              s_q, s_d;
  logic signed [9:0] es_q, es_d;
  logic [23:0]       ma_q, ma_d;
  logic [23:0]       mb_q, mb_d;
  logic [47:0]       p_q, p_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       z_q, z_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              s_in;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       addend;
  logic [23:0]       rnd_sig;
  logic              guard, sticky, round_up;
  logic [24:0]       rnd_sum;
  logic [22:0]       mant;
  logic signed [9:0] es_adj;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  assign s_in   = n1[31] ^ n2[31];
  assign a_zero = (n1[30:23] == 8'h00);
  assign b_zero = (n2[30:23] == 8'h00);
  assign a_inf  = (n1[30:23] == 8'hFF) && (n1[22:0] == 23'h0);
  assign b_inf  = (n2[30:23] == 8'hFF) && (n2[22:0] == 23'h0);
  assign a_nan  = (n1[30:23] == 8'hFF) && (n1[22:0] != 23'h0);
  assign b_nan  = (n2[30:23] == 8'hFF) && (n2[22:0] != 23'h0);

  assign addend = {24'h0, ma_q} << cnt_q;

  // P[47] selects the normalisation; a rounding carry clears bit 23, which masks the field to zero
  always_comb begin
    rnd_sig  = p_q[47] ? p_q[47:24] : p_q[46:23];
    guard    = p_q[47] ? p_q[23] : p_q[22];
    sticky   = p_q[47] ? (|p_q[22:0]) : (|p_q[21:0]);
    round_up = guard & (sticky | rnd_sig[0]);
    rnd_sum  = {1'b0, rnd_sig} + {24'h0, round_up};
    mant     = rnd_sum[22:0] & {23{rnd_sum[23]}};
    es_adj   = es_q - (p_q[47] ? 10'sd126 : 10'sd127) + (rnd_sum[24] ? 10'sd1 : 10'sd0);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    es_d    = es_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d   = s_in;
          es_d  = $signed({2'b00, n1[30:23]}) + $signed({2'b00, n2[30:23]});
          ma_d  = {1'b1, n1[22:0]};
          mb_d  = {1'b1, n2[22:0]};
          p_d   = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            z_d     = 32'h7FC0_0000;
            state_d = DONE;
          end else if (a_inf || b_inf) begin
            z_d     = {s_in, 8'hFF, 23'h0};
            state_d = DONE;
          end else if (a_zero || b_zero) begin
            z_d     = {s_in, 31'h0};
            state_d = DONE;
          end else begin
            state_d = MULT;
          end
        end
      end
      MULT: begin
        if (mb_q[0]) p_d = p_q + addend;
        mb_d  = {1'b0, mb_q[23:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = ROUND;
      end
      ROUND: begin
        if (es_adj >= 10'sd255) begin
          z_d   = {s_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else if (es_adj <= 10'sd0) begin
          z_d   = {s_q, 31'h0};
          unf_d = 1'b1;
        end else begin
          z_d = {s_q, es_adj[7:0], mant};
        end
        state_d = DONE;
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      es_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      es_q    <= es_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_spfp_mul_seq.sv
// tb/tb_spfp_mul_seq.sv - directed scoreboard bench for spfp_mul_seq
module tb_spfp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] n1 = '0;
  logic [31:0] n2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic        ovf;
  logic        unf;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] z;
    logic        ovf;
    logic        unf;
    int          edges;
  } exp_t;
  exp_t sb[$];

  spfp_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .n1(n1), .n2(n2),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ez, input logic eo, input logic eu, input int edges);
    exp_t e;
    e.z = ez; e.ovf = eo; e.unf = eu; e.edges = edges;
    sb.push_back(e);
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    check({tag, " in_ready before accept"}, {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; n1 = a; n2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; n1 = $urandom; n2 = $urandom;
  endtask

  // Called just after the accepting edge; scores latency and result against the queue head.
  task automatic collect(input string tag, input int hold);
    int edges;
    exp_t e;
    logic [31:0] z_hold;
    edges = 0;
    while (!out_valid && edges < 100) begin @(posedge clk); #1; edges++; end
    check({tag, " out_valid seen"}, {31'h0, out_valid}, 32'h1);
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"}, edges, e.edges);
    check({tag, " z"}, z, e.z);
    check({tag, " ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
    check({tag, " unf"}, {31'h0, unf}, {31'h0, e.unf});
    check({tag, " in_ready in DONE"}, {31'h0, in_ready}, 32'h0);
    z_hold = e.z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold z"}, z, z_hold);
      check({tag, " hold out_valid"}, {31'h0, out_valid}, 32'h1);
      check({tag, " hold in_ready"}, {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, {31'h0, out_valid}, 32'h0);
    check({tag, " in_ready after take"}, {31'h0, in_ready}, 32'h1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ez,
                    input logic eo, input logic eu, input int edges, input int hold, input string tag);
    push(ez, eo, eu, edges);
    accept(a, b, tag);
    collect(tag, hold);
  endtask

  initial begin
    #1;
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset z", z, 32'h0);
    check("reset ovf/unf", {30'h0, ovf, unf}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 25, 0, "1.5x2");
    op(32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0, 25, 0, "-3x0.5");
    op(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 25, 0, "round");
    op(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 25, 0, "ovf");
    op(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 25, 0, "unf");
    op(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 0, 0, "inf*0");
    op(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 0, 0, "-inf*2");
    op(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 0, 0, "-0*1");
    op(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0, 0, "denorm");
    op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 25, 10, "backpressure");

    accept(32'h3FC00000, 32'h40000000, "reset-mid");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", {31'h0, in_ready}, 32'h1);
    check("mid reset out_valid", {31'h0, out_valid}, 32'h0);
    check("mid reset z", z, 32'h0);
    check("mid reset ovf/unf", {30'h0, ovf, unf}, 32'h0);
    repeat (30) begin
      @(posedge clk); #1;
      check("in reset out_valid", {31'h0, out_valid}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 25, 0, "1x1 after reset");

    check("scoreboard drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
